writeback_unit: RTL and testbench

WRITEBACK_UNIT -- requirements
Module: writeback_unit

---
 rtl/writeback_unit.sv | 103 ++++++++++
 tb/tb_writeback_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/writeback_unit.sv
// Merges ALU results and a 2-deep in-order load queue onto one register-file write port; 1-cycle registered write.
// Loads backpressured via ld_ready (queue full); ALU held off via a one-cycle alu_stall after 3 starved cycles.
module writeback_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_result,
  output logic        alu_stall,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        reg_write,
  input  logic [4:0]  byp_rs1,
  input  logic [4:0]  byp_rs2,
  output logic        byp_hit1,
  output logic        byp_hit2,
  output logic [31:0] byp_data1,
  output logic [31:0] byp_data2,
  output logic [31:0] pending
);

  typedef struct packed {
    logic        vld;
    logic [4:0]  rd;
    logic [31:0] dat;
  } ent_t;

  ent_t       q0, q1, n0, n1, push_ent;
  logic [1:0] starve, starve_n;
  logic       alu_live, alu_win, pop, push, keep0, keep1;

  // q1 is only ever valid behind a valid q0, so q1.vld means full
  assign ld_ready = ~q1.vld;

  always_comb begin
    alu_live = alu_valid && (alu_rd != 5'd0);
    alu_win  = alu_live && !alu_stall;
    pop      = q0.vld && (alu_stall || !alu_live);
    push_ent = {1'b1, ld_rd, ld_data};
    push     = ld_valid && ld_ready && (ld_rd != 5'd0) && !(alu_win && (ld_rd == alu_rd));
    keep0    = q0.vld && !pop && !(alu_win && (q0.rd == alu_rd));
    keep1    = q1.vld && !(alu_win && (q1.rd == alu_rd));

    // survivors compact toward the head in original order, then the new load appends
    n0 = '0;
    n1 = '0;
    if (keep0) begin
      n0 = q0;
      if (keep1)     n1 = q1;
      else if (push) n1 = push_ent;
    end else if (keep1) begin
      n0 = q1;
      if (push) n1 = push_ent;
    end else if (push) begin
      n0 = push_ent;
    end

    if (pop || !q0.vld) starve_n = 2'd0;
    else if (alu_win)   starve_n = starve + 2'd1;
    else                starve_n = starve;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      q0         <= '0;
      q1         <= '0;
      starve     <= 2'd0;
      alu_stall  <= 1'b0;
      reg_write  <= 1'b0;
      write_reg  <= 5'd0;
      write_data <= 32'd0;
    end else begin
      q0        <= n0;
      q1        <= n1;
      starve    <= starve_n;
      alu_stall <= (starve_n == 2'd3);
      reg_write <= pop || alu_win;
      if (pop) begin
        write_reg  <= q0.rd;
        write_data <= q0.dat;
      end else if (alu_win) begin
        write_reg  <= alu_rd;
        write_data <= alu_result;
      end
    end
  end

  assign byp_hit1  = reg_write && (write_reg == byp_rs1) && (byp_rs1 != 5'd0);
  assign byp_hit2  = reg_write && (write_reg == byp_rs2) && (byp_rs2 != 5'd0);
  assign byp_data1 = byp_hit1 ? write_data : 32'd0;
  assign byp_data2 = byp_hit2 ? write_data : 32'd0;

  always_comb begin
    pending = 32'd0;
    if (q0.vld) pending[q0.rd] = 1'b1;
    if (q1.vld) pending[q1.rd] = 1'b1;
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: queue-based reference model, directed scenarios then random traffic.
module tb_writeback_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_result;
  logic        alu_stall;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        reg_write;
  logic [4:0]  byp_rs1, byp_rs2;
  logic        byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;
  logic [31:0] pending;

  always #5 clk = ~clk;

  writeback_unit dut (
    .clk(clk), .reset(reset),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_result(alu_result), .alu_stall(alu_stall),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
    .write_reg(write_reg), .write_data(write_data), .reg_write(reg_write),
    .byp_rs1(byp_rs1), .byp_rs2(byp_rs2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
    .byp_data1(byp_data1), .byp_data2(byp_data2), .pending(pending)
  );

  typedef struct { bit we; logic [4:0] rd; logic [31:0] dat; } exp_t;
  typedef struct { logic [4:0] rd; logic [31:0] dat; } ld_t;

  exp_t        exp_q[$];
  ld_t         m_q[$];
  int          m_lost = 0;
  bit          m_stall = 1'b0;
  bit          m_we = 1'b0;
  logic [4:0]  m_reg = 5'd0;
  logic [31:0] m_dat = 32'd0;
  int          checks = 0;
  int          errors = 0;
  bit          chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_pending();
    logic [31:0] p;
    p = 32'd0;
    foreach (m_q[i]) p[m_q[i].rd] = 1'b1;
    return p;
  endfunction

  function automatic logic [31:0] m_byp(input logic [4:0] rs);
    return (m_we && m_reg == rs && rs != 5'd0) ? m_dat : 32'd0;
  endfunction

  // One clock: check visible state against the model, drive inputs, advance the model, wait for next negedge.
  task automatic step(input bit rn, input bit av, input logic [4:0] ard, input logic [31:0] ares,
                      input bit lv, input logic [4:0] lrd, input logic [31:0] ldat,
                      input logic [4:0] r1, input logic [4:0] r2);
    bit  ready, nonempty, won, popped;
    ld_t head;
    reset = rn; alu_valid = av; alu_rd = ard; alu_result = ares;
    ld_valid = lv; ld_rd = lrd; ld_data = ldat; byp_rs1 = r1; byp_rs2 = r2;
    #1;
    if (chk_en) begin
      chk("ld_ready", {31'd0, ld_ready}, {31'd0, m_q.size() < 2});
      chk("pending", pending, m_pending());
      chk("alu_stall", {31'd0, alu_stall}, {31'd0, m_stall});
      chk("byp_hit1", {31'd0, byp_hit1}, {31'd0, m_we && m_reg == r1 && r1 != 5'd0});
      chk("byp_hit2", {31'd0, byp_hit2}, {31'd0, m_we && m_reg == r2 && r2 != 5'd0});
      chk("byp_data1", byp_data1, m_byp(r1));
      chk("byp_data2", byp_data2, m_byp(r2));
    end
    if (!rn) begin
      m_q.delete();
      m_lost = 0; m_stall = 1'b0; m_we = 1'b0; m_reg = 5'd0; m_dat = 32'd0;
    end else begin
      ready    = m_q.size() < 2;
      nonempty = m_q.size() > 0;
      won = 1'b0; popped = 1'b0; m_we = 1'b0;
      if (m_stall && nonempty)                  popped = 1'b1;
      else if (!m_stall && av && ard != 5'd0)   won = 1'b1;
      else if (!m_stall && nonempty)            popped = 1'b1;
      if (popped) begin
        head = m_q.pop_front();
        m_we = 1'b1; m_reg = head.rd; m_dat = head.dat;
      end
      if (won) begin
        m_we = 1'b1; m_reg = ard; m_dat = ares;
        for (int i = m_q.size() - 1; i >= 0; i--)
          if (m_q[i].rd == ard) m_q.delete(i);
      end
      if (lv && ready && lrd != 5'd0 && !(won && lrd == ard)) m_q.push_back('{lrd, ldat});
      if (popped || !nonempty) m_lost = 0;
      else if (won)            m_lost++;
      m_stall = (m_lost == 3);
    end
    exp_q.push_back('{m_we, m_reg, m_dat});
    chk_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
  endtask

  // Monitor: every cycle the DUT write port must match the next scoreboard entry.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("reg_write", {31'd0, reg_write}, {31'd0, e.we});
        chk("write_reg", {27'd0, write_reg}, {27'd0, e.rd});
        chk("write_data", write_data, e.dat);
      end
    end
  end

  initial begin
    bit          rn, hold;
    bit          pav;
    logic [4:0]  pard;
    logic [31:0] pares;
    hold = 1'b0; pav = 1'b0; pard = 5'd0; pares = 32'd0;

    step(1'b0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd3, 32'd7, 1'b1, 5'd3, 32'd8, 5'd0, 5'd0);

    // ALU write and bypass
    step(1'b1, 1'b1, 5'd5, 32'h1234, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    chk("r27_reg_write", {31'd0, reg_write}, 32'd1);
    chk("r27_write_reg", {27'd0, write_reg}, 32'd5);
    chk("r27_write_data", write_data, 32'h1234);
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);

    // Two loads queued behind a busy ALU, then drained in order
    step(1'b1, 1'b1, 5'd9, 32'h1, 1'b1, 5'd3, 32'hA, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd10, 32'h2, 1'b1, 5'd4, 32'hB, 5'd0, 5'd0);
    chk("r28_ld_ready", {31'd0, ld_ready}, 32'd0);
    chk("r28_pending", pending, 32'h18);
    idle();
    chk("r28_first_reg", {27'd0, write_reg}, 32'd3);
    chk("r28_first_data", write_data, 32'hA);
    idle();
    chk("r28_second_reg", {27'd0, write_reg}, 32'd4);
    chk("r28_second_data", write_data, 32'hB);
    chk("r28_pending_clear", pending, 32'd0);

    // ALU write squashes an older queued load to the same register
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h55, 5'd0, 5'd0);
    chk("r29_pending", pending, 32'h80);
    step(1'b1, 1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    chk("r29_pending_clear", pending, 32'd0);
    chk("r29_write_data", write_data, 32'h99);
    idle();
    chk("r29_no_second_write", {31'd0, reg_write}, 32'd0);

    // Starvation relief for a load behind a continuously busy ALU
    step(1'b1, 1'b0, 5'd0, 32'd0, 1'b1, 5'd2, 32'h22, 5'd0, 5'd0);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 1'b1, 5'd9, 32'h909, 1'b0, 5'd0, 32'd0, 5'd2, 5'd9);
      if (i == 2) chk("r30_stall_on", {31'd0, alu_stall}, 32'd1);
      if (i == 3) begin
        chk("r30_load_reg", {27'd0, write_reg}, 32'd2);
        chk("r30_load_data", write_data, 32'h22);
        chk("r30_stall_off", {31'd0, alu_stall}, 32'd0);
      end
      if (i == 4) chk("r30_alu_resumes", {27'd0, write_reg}, 32'd9);
    end

    // Writes and loads to r0 are dropped
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 5'd0, 32'hDEAD, 1'b1, 5'd0, 32'hBEEF, 5'd0, 5'd0);
      chk("r31_ld_ready", {31'd0, ld_ready}, 32'd1);
      if (i > 0) chk("r31_no_write", {31'd0, reg_write}, 32'd0);
    end

    // Reset with a full queue
    step(1'b1, 1'b1, 5'd11, 32'h1, 1'b1, 5'd12, 32'hC, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd13, 32'h2, 1'b1, 5'd14, 32'hD, 5'd0, 5'd0);
    chk("r32_pending_full", pending, 32'h5000);
    step(1'b0, 1'b1, 5'd15, 32'h3, 1'b1, 5'd16, 32'hE, 5'd0, 5'd0);
    chk("r32_reg_write", {31'd0, reg_write}, 32'd0);
    chk("r32_pending", pending, 32'd0);
    idle();
    chk("r32_ld_ready", {31'd0, ld_ready}, 32'd1);

    // Random traffic on a small register range to force collisions
    for (int n = 0; n < 3000; n++) begin
      rn = ($urandom_range(0, 249) != 0);
      if (!hold) begin
        pav   = ($urandom_range(0, 99) < 55);
        pard  = 5'($urandom_range(0, 7));
        pares = $urandom;
      end
      hold = m_stall && rn;
      step(rn, pav, pard, pares,
           ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), ($urandom_range(0, 3) == 0) ? m_reg : 5'($urandom_range(0, 7)));
    end

    for (int i = 0; i < 5; i++) idle();
    @(posedge clk);
    #2;
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
